// File: rtl/axi_lite_master_bridge_if.sv
// AXI-Lite bus bundle between the command/response bridge and an AXI-Lite slave.
// Carries the five AXI-Lite channels:
//   AW: AWADDR, AWVALID (master->slave), AWREADY (slave->master)
//   W : WDATA, WVALID (master->slave), WREADY (slave->master)
//   B : BRESP, BVALID (slave->master), BREADY (master->slave)
//   AR: ARADDR, ARVALID (master->slave), ARREADY (slave->master)
//   R : RDATA, RRESP, RVALID (slave->master), RREADY (master->slave)
// Modports: master (bridge side), slave (memory side).
interface axi_lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding bridge from a simple command/response interface to an
// AXI-Lite master. One command is accepted in IDLE, issued on AW+W or AR,
// its B/R response captured, then presented on the rsp_* port with the
// number of cycles from command accept to the B/R handshake.
// Ports:
//   ACLK, ARESETn        clock (posedge) and asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready  response handshake; rsp_write, rsp_rdata,
//                        rsp_resp, rsp_latency (saturating)
//   axi                  AXI-Lite master side of the bus bundle
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [LAT_WIDTH-1:0]  rsp_latency,
  axi_lite_master_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  write_reg;
  logic                  aw_valid_reg, w_valid_reg, ar_valid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            resp_reg;
  logic [LAT_WIDTH-1:0]  lat_reg;

  logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, busy;

  assign accept = (state_reg == IDLE) && cmd_valid;
  assign aw_hs  = aw_valid_reg && axi.AWREADY;
  assign w_hs   = w_valid_reg  && axi.WREADY;
  assign ar_hs  = ar_valid_reg && axi.ARREADY;
  // BREADY/RREADY are a pure function of state, so these are the handshakes.
  assign b_hs   = (state_reg == WR_RESP) && axi.BVALID;
  assign r_hs   = (state_reg == RD_RESP) && axi.RVALID;
  assign busy   = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                  (state_reg == RD_REQ) || (state_reg == RD_RESP);

  assign axi.AWADDR  = addr_reg;
  assign axi.ARADDR  = addr_reg;
  assign axi.WDATA   = wdata_reg;
  assign axi.AWVALID = aw_valid_reg;
  assign axi.WVALID  = w_valid_reg;
  assign axi.ARVALID = ar_valid_reg;

  assign rsp_write   = write_reg;
  assign rsp_rdata   = rdata_reg;
  assign rsp_resp    = resp_reg;
  assign rsp_latency = lat_reg;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    axi.BREADY = 1'b0;
    axi.RREADY = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // A channel whose VALID is already low has completed earlier.
        if ((!aw_valid_reg || aw_hs) && (!w_valid_reg || w_hs)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) begin
          state_next = RSP;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        axi.RREADY = 1'b1;
        if (axi.RVALID) begin
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      ar_valid_reg <= 1'b0;
      rdata_reg    <= '0;
      resp_reg     <= 2'b00;
      lat_reg      <= '0;
    end else begin
      if (accept) begin
        addr_reg     <= cmd_addr;
        wdata_reg    <= cmd_wdata;
        write_reg    <= cmd_write;
        aw_valid_reg <= cmd_write;
        w_valid_reg  <= cmd_write;
        ar_valid_reg <= !cmd_write;
        // Cleared on accept, and the accept cycle itself already counts.
        lat_reg      <= LAT_WIDTH'(1);
      end else begin
        if (aw_hs) aw_valid_reg <= 1'b0;
        if (w_hs)  w_valid_reg  <= 1'b0;
        if (ar_hs) ar_valid_reg <= 1'b0;
        if (busy && (lat_reg != {LAT_WIDTH{1'b1}})) begin
          lat_reg <= lat_reg + LAT_WIDTH'(1);
        end
      end
      if (b_hs) begin
        resp_reg  <= axi.BRESP;
        rdata_reg <= '0;
      end
      if (r_hs) begin
        resp_reg  <= axi.RRESP;
        rdata_reg <= axi.RDATA;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge with a small behavioural
// AXI-Lite memory slave whose per-channel wait states and response codes
// are configurable. Expected responses go into a scoreboard queue when a
// command is issued and are compared when the bridge presents a response.
module tb_axi_lite_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [LW-1:0] rsp_latency;

  always #5 ACLK = ~ACLK;

  axi_lite_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_lite_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .axi(axi)
  );

  // ---------------- behavioural slave ----------------
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_hs_count;
  logic aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] awaddr_q, wr_addr;
  logic [DW-1:0] wdata_q, wr_data, rdata_q;
  logic [DW-1:0] mem [256];
  logic s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

  assign axi.AWREADY = axi.AWVALID && !aw_got && (aw_cnt >= aw_delay);
  assign axi.WREADY  = axi.WVALID && !w_got && (w_cnt >= w_delay);
  assign axi.BVALID  = b_pend && (b_cnt >= b_delay);
  assign axi.BRESP   = b_resp_cfg;
  assign axi.ARREADY = axi.ARVALID && !r_pend && (ar_cnt >= ar_delay);
  assign axi.RVALID  = r_pend && (r_cnt >= r_delay);
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = r_resp_cfg;

  assign s_aw_hs = axi.AWVALID && axi.AWREADY;
  assign s_w_hs  = axi.WVALID && axi.WREADY;
  assign s_b_hs  = axi.BVALID && axi.BREADY;
  assign s_ar_hs = axi.ARVALID && axi.ARREADY;
  assign s_r_hs  = axi.RVALID && axi.RREADY;
  assign wr_addr = s_aw_hs ? axi.AWADDR : awaddr_q;
  assign wr_data = s_w_hs ? axi.WDATA : wdata_q;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      awaddr_q <= '0; wdata_q <= '0; rdata_q <= '0;
    end else begin
      if (axi.AWVALID && !aw_got && !s_aw_hs) aw_cnt <= aw_cnt + 1;
      if (s_aw_hs) begin aw_cnt <= 0; awaddr_q <= axi.AWADDR; end
      if (axi.WVALID && !w_got && !s_w_hs) w_cnt <= w_cnt + 1;
      if (s_w_hs) begin w_cnt <= 0; wdata_q <= axi.WDATA; end
      if (b_pend && !axi.BVALID) b_cnt <= b_cnt + 1;
      if (s_b_hs) begin b_pend <= 1'b0; b_hs_count <= b_hs_count + 1; end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        mem[wr_addr[9:2]] <= wr_data;
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (s_aw_hs) aw_got <= 1'b1;
        if (s_w_hs)  w_got  <= 1'b1;
      end
      if (axi.ARVALID && !r_pend && !s_ar_hs) ar_cnt <= ar_cnt + 1;
      if (r_pend && !axi.RVALID) r_cnt <= r_cnt + 1;
      if (s_r_hs) r_pend <= 1'b0;
      if (s_ar_hs) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
        rdata_q <= mem[axi.ARADDR[9:2]];
      end
    end
  end

  initial b_hs_count = 0;

  // ---------------- scoreboard and checks ----------------
  typedef struct {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic [LW-1:0] lat;
  } exp_t;
  exp_t sb_q[$];

  int tests = 0;
  int failed = 0;
  int b_start = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [LW-1:0] sat_lat(input int v);
    int m;
    m = (1 << LW) - 1;
    if (v > m) v = m;
    return v[LW-1:0];
  endfunction

  // Drive a command, push its expected response, wait for accept.
  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [1:0] resp);
    exp_t e;
    int n;
    e.write = wr;
    e.rdata = wr ? '0 : data;
    e.resp  = resp;
    e.lat   = wr ? sat_lat(((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay + 3)
                 : sat_lat(ar_delay + r_delay + 3);
    sb_q.push_back(e);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wr ? data : DW'($urandom);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    b_start = b_hs_count;
    if (wr) begin
      check("awvalid_first", axi.AWVALID, 1);
      check("wvalid_first", axi.WVALID, 1);
      check("awaddr", axi.AWADDR, addr);
      check("wdata", axi.WDATA, data);
    end else begin
      check("arvalid_first", axi.ARVALID, 1);
      check("araddr", axi.ARADDR, addr);
    end
    $display("[TB] cmd %s addr=%08h data=%08h accepted", wr ? "WR" : "RD", addr, data);
  endtask

  // Watch channel protocol until the response appears, compare it, hold it
  // for `hold` cycles with rsp_ready low, then complete the handshake.
  task automatic finish_rsp(input int hold);
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_resp;
    logic [LW-1:0] s_lat;
    logic s_write;
    exp_t e;
    int n;
    p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awaddr = axi.AWADDR;
    p_wv = axi.WVALID; p_wr = axi.WREADY; p_wdata = axi.WDATA;
    p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_araddr = axi.ARADDR;
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
      if (p_awv && !p_awr) begin
        check("awvalid_held", axi.AWVALID, 1);
        check("awaddr_stable", axi.AWADDR, p_awaddr);
      end
      if (p_awv && p_awr) check("awvalid_drop", axi.AWVALID, 0);
      if (p_wv && !p_wr) begin
        check("wvalid_held", axi.WVALID, 1);
        check("wdata_stable", axi.WDATA, p_wdata);
      end
      if (p_wv && p_wr) check("wvalid_drop", axi.WVALID, 0);
      if (p_arv && !p_arr) begin
        check("arvalid_held", axi.ARVALID, 1);
        check("araddr_stable", axi.ARADDR, p_araddr);
      end
      if (p_arv && p_arr) check("arvalid_drop", axi.ARVALID, 0);
      p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awaddr = axi.AWADDR;
      p_wv = axi.WVALID; p_wr = axi.WREADY; p_wdata = axi.WDATA;
      p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_araddr = axi.ARADDR;
    end
    check("rsp_valid_wait", rsp_valid, 1);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("rsp_write", rsp_write, e.write);
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_resp", rsp_resp, e.resp);
      check("rsp_latency", rsp_latency, e.lat);
      $display("[TB] rsp write=%0d rdata=%08h resp=%0d lat=%0d (exp %0d/%08h/%0d/%0d)",
               rsp_write, rsp_rdata, rsp_resp, rsp_latency, e.write, e.rdata, e.resp, e.lat);
    end
    s_rdata = rsp_rdata; s_resp = rsp_resp; s_lat = rsp_latency; s_write = rsp_write;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_rdata", rsp_rdata, s_rdata);
      check("hold_resp", rsp_resp, s_resp);
      check("hold_latency", rsp_latency, s_lat);
      check("hold_write", rsp_write, s_write);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", rsp_valid, 0);
    check("idle_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid", axi.WVALID, 0);
    check("rst_arvalid", axi.ARVALID, 0);
    check("rst_bready", axi.BREADY, 0);
    check("rst_rready", axi.RREADY, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_rsp_latency", rsp_latency, 0);
    ARESETn = 1'b1;
    step();

    // Zero-wait write then read-back
    start_cmd(1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    finish_rsp(0);
    check("b_handshakes_w1", b_hs_count - b_start, 1);
    start_cmd(1'b0, 32'h10, 32'hDEADBEEF, 2'b00);
    finish_rsp(0);

    // AW delayed 3, W delayed 1
    aw_delay = 3; w_delay = 1;
    start_cmd(1'b1, 32'h14, 32'h12345678, 2'b00);
    finish_rsp(0);
    check("b_handshakes_w2", b_hs_count - b_start, 1);

    // W completes after AW, B delayed
    aw_delay = 0; w_delay = 2; b_delay = 1;
    start_cmd(1'b1, 32'h20, 32'h0BADF00D, 2'b00);
    finish_rsp(0);
    check("b_handshakes_w3", b_hs_count - b_start, 1);
    w_delay = 0; b_delay = 0;

    // Error responses pass through
    b_resp_cfg = 2'b10;
    start_cmd(1'b1, 32'h18, 32'hCAFEBABE, 2'b10);
    finish_rsp(0);
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11; ar_delay = 2;
    start_cmd(1'b0, 32'h14, 32'h12345678, 2'b11);
    finish_rsp(0);
    r_resp_cfg = 2'b00; ar_delay = 0;

    // Response back-pressure with the next command already waiting
    start_cmd(1'b1, 32'h1C, 32'hA5A5A5A5, 2'b00);
    cmd_write = 1'b0; cmd_addr = 32'h1C; cmd_valid = 1'b1;
    finish_rsp(5);
    start_cmd(1'b0, 32'h1C, 32'hA5A5A5A5, 2'b00);
    finish_rsp(0);

    // Latency saturation
    r_delay = 20;
    start_cmd(1'b0, 32'h20, 32'h0BADF00D, 2'b00);
    finish_rsp(0);

    // Reset while waiting for R
    r_delay = 10;
    start_cmd(1'b0, 32'h10, 32'hDEADBEEF, 2'b00);
    n = 0;
    while (!axi.RREADY && n < 50) begin step(); n++; end
    check("reach_rd_resp", axi.RREADY, 1);
    step();
    ARESETn = 1'b0;
    #1;
    check("mid_rst_awvalid", axi.AWVALID, 0);
    check("mid_rst_wvalid", axi.WVALID, 0);
    check("mid_rst_arvalid", axi.ARVALID, 0);
    check("mid_rst_rready", axi.RREADY, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    void'(sb_q.pop_front());
    $display("[TB] read aborted by reset");
    step();
    ARESETn = 1'b1;
    r_delay = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    start_cmd(1'b1, 32'h24, 32'h13579BDF, 2'b00);
    finish_rsp(0);
    start_cmd(1'b0, 32'h24, 32'h13579BDF, 2'b00);
    finish_rsp(0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
